hpi_txn_sequencer: RTL

- Hardware transaction engine directly upstream of the HPI pin interface block (the one that registers strobes/address/data onto OTG_* pins and registers OTG_DATA back).
- Converts single-word read/write requests (direct HPI register, or indirect memory access via the ADDRESS register) into correctly timed active-low CS/RD/WR strobe sequences, and captures read data.
- Replaces software bit-banging of the HPI strobes. Output timing accounts for the 1-cycle register stage in each direction of the downstream block.

---
 rtl/hpi_txn_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hpi_txn_sequencer.sv
// Turns single-word HPI read/write requests into timed active-low CS/RD/WR strobe
// sequences for the downstream pin interface, with an ADDRESS phase ahead of memory accesses.
module hpi_txn_sequencer #(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 4,
   parameter int unsigned HOLD_CYC   = 2,
   parameter int unsigned RECOV_CYC  = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic        req_mem_i,
   input  logic [1:0]  req_reg_i,
   input  logic [15:0] req_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        busy_o,
   output logic [1:0]  hpi_address_o,
   output logic [15:0] hpi_data_out_o,
   input  logic [15:0] hpi_data_in_i,
   output logic        hpi_r_o,
   output logic        hpi_w_o,
   output logic        hpi_cs_o
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP} state_e;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOV_LD  = 4'(RECOV_CYC - 1);
   localparam logic [3:0] CAPT_CNT  = 4'(HOLD_CYC - 2);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        addrPhase_q, addrPhase_d;
   logic        write_q, mem_q;
   logic [1:0]  reg_q;
   logic [15:0] addr_q, wdata_q, rdata_q;

   logic        accept, capture, phaseWrite;
   logic [1:0]  phaseReg;
   logic [15:0] phaseWdata;

   assign accept = req_valid_i && (state_q == IDLE);

   // The ADDR phase of a memory access always writes the latched address to register 2.
   assign phaseReg   = addrPhase_q ? 2'd2 : (mem_q ? 2'd0 : reg_q);
   assign phaseWrite = addrPhase_q | write_q;
   assign phaseWdata = addrPhase_q ? addr_q : wdata_q;

   // Pin data lags the strobe by two register stages, so sample in the second HOLD cycle.
   assign capture = (state_q == HOLD) && (cnt_q == CAPT_CNT) && !phaseWrite;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addrPhase_q <= 1'b0;
         write_q     <= 1'b0;
         mem_q       <= 1'b0;
         reg_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addrPhase_q <= addrPhase_d;
         if (accept) begin
            write_q <= req_write_i;
            mem_q   <= req_mem_i;
            reg_q   <= req_reg_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (capture) begin
            rdata_q <= hpi_data_in_i;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      addrPhase_d = addrPhase_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = SETUP;
               cnt_d       = SETUP_LD;
               addrPhase_d = req_mem_i;
            end
         end
         SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = GAP;
               cnt_d   = RECOV_LD;
            end
         end
         GAP: begin
            if (cnt_q == 4'd0) begin
               if (addrPhase_q) begin
                  state_d     = SETUP;
                  cnt_d       = SETUP_LD;
                  addrPhase_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hpi_cs_o       = 1'b1;
      hpi_r_o        = 1'b1;
      hpi_w_o        = 1'b1;
      hpi_address_o  = 2'd0;
      hpi_data_out_o = 16'd0;
      rsp_valid_o    = 1'b0;
      case (state_q)
         SETUP, STROBE, HOLD: begin
            hpi_cs_o       = 1'b0;
            hpi_address_o  = phaseReg;
            hpi_data_out_o = phaseWdata;
            if (state_q == STROBE) begin
               hpi_w_o = !phaseWrite;
               hpi_r_o = phaseWrite;
            end
         end
         GAP: rsp_valid_o = !addrPhase_q && (cnt_q == RECOV_LD);
         default: ;
      endcase
   end

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign busy_o      = !req_ready_o;
   assign rsp_rdata_o = rdata_q;

endmodule
